add_h_border: RTL and testbench

Multi-flux horizontal border extension stage sitting directly upstream of the horizontal border removal stage in the Mulfwd path. Per block it reads one size token S, forwards it, then emits S rows of pels. Each row is extended by PAD_L copies of its first pel on the left and PAD_R copies of its last pel on the right. Up to FLUX independent tagged streams share the block; one FIFO operation is performed per cycle, arbitrated per flux.

---
 rtl/hevc_border_pkg.sv | 22 ++
 rtl/flux_prio_arbiter.sv | 23 ++
 rtl/add_h_border.sv | 188 ++++++++++++++++++
 tb/tb_add_h_border.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hevc_border_pkg.sv
// Shared types and defaults for the horizontal border extension/removal stages.
// Holds the per-flux state encoding and the tag-width helper.
package hevc_border_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    BODY  = 2'd2,
    RIGHT = 2'd3
  } border_state_t;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_SIZE_WIDTH = 7;
  localparam int DEF_PAD_L      = 7;
  localparam int DEF_PAD_R      = 8;

  // A single flux still carries a 1-bit tag so no port collapses to zero width.
  function automatic int tag_width(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/flux_prio_arbiter.sv
// Fixed-priority flux selector: lowest eligible index wins.
// Shared between the border extension and border removal stages.
module flux_prio_arbiter #(
  parameter int N  = 2,
  parameter int TW = 1
) (
  input  logic [N-1:0]  eligible,
  output logic [TW-1:0] tag,
  output logic          valid
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    tag   = '0;
    valid = |eligible;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        tag = TW'(i);
      end
    end
  end

endmodule

// File: rtl/add_h_border.sv
// Multi-flux horizontal border extension: forwards each size token S, then emits
// S rows of PAD_L copies of the first pel, the S pels, and PAD_R copies of the last.
module add_h_border
  import hevc_border_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int PAD_L      = DEF_PAD_L,
  parameter int PAD_R      = DEF_PAD_R,
  localparam int TAG_WIDTH = tag_width(FLUX)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [FLUX-1:0][DATA_WIDTH+TAG_WIDTH-1:0] in_pel_dout,
  input  logic [FLUX-1:0]                           in_pel_empty,
  output logic [FLUX-1:0]                           in_pel_read,
  input  logic [FLUX-1:0][SIZE_WIDTH+TAG_WIDTH-1:0] ext_size_dout,
  input  logic [FLUX-1:0]                           ext_size_empty,
  output logic [FLUX-1:0]                           ext_size_read,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]           out_pel_din,
  input  logic [FLUX-1:0]                           out_pel_full,
  output logic [FLUX-1:0]                           out_pel_write,
  output logic [SIZE_WIDTH+TAG_WIDTH-1:0]           out_size_din,
  input  logic [FLUX-1:0]                           out_size_full,
  output logic [FLUX-1:0]                           out_size_write,
  output logic [FLUX-1:0][1:0]                      dbg_state,
  output logic [FLUX-1:0][7:0]                      dbg_cnt_h
);

  // Handshake: inputs are show-ahead FIFOs; dout[i] is valid whenever empty[i] is
  // low and read[i] pops it at the rising edge. Outputs accept din when write[i]
  // is high and full[i] is low. Strobes are combinational and never wait on
  // themselves, and only the winning flux may strobe in a given cycle.

  localparam logic [7:0] PAD_L_LAST = 8'(PAD_L - 1);
  localparam logic [7:0] PAD_R_LAST = 8'(PAD_R - 1);

  border_state_t         state_q    [FLUX];
  logic [SIZE_WIDTH-1:0] size_q     [FLUX];
  logic [7:0]            cnt_h_q    [FLUX];
  logic [7:0]            cnt_v_q    [FLUX];
  logic [DATA_WIDTH-1:0] last_pel_q [FLUX];

  logic [FLUX-1:0]       eligible;
  logic [TAG_WIDTH-1:0]  sel;
  logic                  grant;

  border_state_t         nxt_state;
  logic [SIZE_WIDTH-1:0] nxt_size;
  logic [7:0]            nxt_cnt_h;
  logic [7:0]            nxt_cnt_v;
  logic [DATA_WIDTH-1:0] nxt_last;
  logic [DATA_WIDTH-1:0] cur_pel;
  logic [SIZE_WIDTH-1:0] new_size;
  logic [7:0]            size_last;

  // Input tags are implied by the per-flux port index, so their bits are unused.
  logic [2*FLUX*TAG_WIDTH-1:0] unused_tags;

  always_comb begin
    unused_tags = '0;
    for (int i = 0; i < FLUX; i++) begin
      unused_tags[i*TAG_WIDTH +: TAG_WIDTH] = in_pel_dout[i][DATA_WIDTH +: TAG_WIDTH];
      unused_tags[(FLUX+i)*TAG_WIDTH +: TAG_WIDTH] =
        ext_size_dout[i][SIZE_WIDTH +: TAG_WIDTH];
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < FLUX; i++) begin
      case (state_q[i])
        IDLE:       eligible[i] = !ext_size_empty[i] && !out_size_full[i];
        LEFT, BODY: eligible[i] = !in_pel_empty[i] && !out_pel_full[i];
        default:    eligible[i] = !out_pel_full[i];
      endcase
    end
  end

  flux_prio_arbiter #(
    .N  (FLUX),
    .TW (TAG_WIDTH)
  ) u_arb (
    .eligible (eligible),
    .tag      (sel),
    .valid    (grant)
  );

  // Strobes, din and the next register values of the granted flux only.
  always_comb begin
    in_pel_read    = '0;
    ext_size_read  = '0;
    out_pel_write  = '0;
    out_size_write = '0;
    out_pel_din    = '0;
    out_size_din   = '0;
    nxt_state      = state_q[sel];
    nxt_size       = size_q[sel];
    nxt_cnt_h      = cnt_h_q[sel];
    nxt_cnt_v      = cnt_v_q[sel];
    nxt_last       = last_pel_q[sel];
    cur_pel        = in_pel_dout[sel][DATA_WIDTH-1:0];
    new_size       = ext_size_dout[sel][SIZE_WIDTH-1:0];
    size_last      = 8'(size_q[sel]) - 8'd1;

    if (grant && rst) begin
      case (state_q[sel])
        IDLE: begin
          ext_size_read[sel]  = 1'b1;
          out_size_write[sel] = 1'b1;
          out_size_din        = {sel, new_size};
          nxt_size            = new_size;
          nxt_cnt_h           = 8'd0;
          nxt_cnt_v           = 8'd0;
          nxt_state           = (new_size == '0) ? IDLE : LEFT;
        end
        LEFT: begin
          // Peek only: the first pel is consumed later in BODY.
          out_pel_write[sel] = 1'b1;
          out_pel_din        = {sel, cur_pel};
          if (cnt_h_q[sel] == PAD_L_LAST) begin
            nxt_cnt_h = 8'd0;
            nxt_state = BODY;
          end else begin
            nxt_cnt_h = cnt_h_q[sel] + 8'd1;
          end
        end
        BODY: begin
          in_pel_read[sel]   = 1'b1;
          out_pel_write[sel] = 1'b1;
          out_pel_din        = {sel, cur_pel};
          nxt_last           = cur_pel;
          if (cnt_h_q[sel] == size_last) begin
            nxt_cnt_h = 8'd0;
            nxt_state = RIGHT;
          end else begin
            nxt_cnt_h = cnt_h_q[sel] + 8'd1;
          end
        end
        default: begin
          out_pel_write[sel] = 1'b1;
          out_pel_din        = {sel, last_pel_q[sel]};
          if (cnt_h_q[sel] == PAD_R_LAST) begin
            nxt_cnt_h = 8'd0;
            if (cnt_v_q[sel] == size_last) begin
              nxt_cnt_v = 8'd0;
              nxt_state = IDLE;
            end else begin
              nxt_cnt_v = cnt_v_q[sel] + 8'd1;
              nxt_state = LEFT;
            end
          end else begin
            nxt_cnt_h = cnt_h_q[sel] + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) begin
        state_q[i]    <= IDLE;
        size_q[i]     <= '0;
        cnt_h_q[i]    <= '0;
        cnt_v_q[i]    <= '0;
        last_pel_q[i] <= '0;
      end
    end else if (grant) begin
      state_q[sel]    <= nxt_state;
      size_q[sel]     <= nxt_size;
      cnt_h_q[sel]    <= nxt_cnt_h;
      cnt_v_q[sel]    <= nxt_cnt_v;
      last_pel_q[sel] <= nxt_last;
    end
  end

  always_comb begin
    dbg_state = '0;
    dbg_cnt_h = '0;
    for (int i = 0; i < FLUX; i++) begin
      dbg_state[i] = state_q[i];
      dbg_cnt_h[i] = cnt_h_q[i];
    end
  end

endmodule

// File: tb/tb_add_h_border.sv
// Directed bench for add_h_border: FIFO models on every port, expected pels and
// sizes queued per flux at load time and checked by an independent monitor.
module tb_add_h_border;
  import hevc_border_pkg::*;

  localparam int FLUX = 2;
  localparam int DW   = 18;
  localparam int SW   = 7;
  localparam int TW   = 1;
  localparam int PL   = 7;
  localparam int PR   = 8;
  localparam int PW   = DW + TW;
  localparam int SZW  = SW + TW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [FLUX-1:0][PW-1:0]  in_pel_dout;
  logic [FLUX-1:0]          in_pel_empty;
  logic [FLUX-1:0]          in_pel_read;
  logic [FLUX-1:0][SZW-1:0] ext_size_dout;
  logic [FLUX-1:0]          ext_size_empty;
  logic [FLUX-1:0]          ext_size_read;
  logic [PW-1:0]            out_pel_din;
  logic [FLUX-1:0]          out_pel_full;
  logic [FLUX-1:0]          out_pel_write;
  logic [SZW-1:0]           out_size_din;
  logic [FLUX-1:0]          out_size_full;
  logic [FLUX-1:0]          out_size_write;
  logic [FLUX-1:0][1:0]     dbg_state;
  logic [FLUX-1:0][7:0]     dbg_cnt_h;

  add_h_border #(
    .FLUX       (FLUX),
    .DATA_WIDTH (DW),
    .SIZE_WIDTH (SW),
    .PAD_L      (PL),
    .PAD_R      (PR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_pel_dout    (in_pel_dout),
    .in_pel_empty   (in_pel_empty),
    .in_pel_read    (in_pel_read),
    .ext_size_dout  (ext_size_dout),
    .ext_size_empty (ext_size_empty),
    .ext_size_read  (ext_size_read),
    .out_pel_din    (out_pel_din),
    .out_pel_full   (out_pel_full),
    .out_pel_write  (out_pel_write),
    .out_size_din   (out_size_din),
    .out_size_full  (out_size_full),
    .out_size_write (out_size_write),
    .dbg_state      (dbg_state),
    .dbg_cnt_h      (dbg_cnt_h)
  );

  logic [PW-1:0]  in_q       [FLUX][$];
  logic [SZW-1:0] sz_q       [FLUX][$];
  logic [PW-1:0]  exp_q      [FLUX][$];
  logic [SZW-1:0] exp_size_q [FLUX][$];
  int             pel_cnt  [FLUX] = '{default: 0};
  int             size_cnt [FLUX] = '{default: 0};
  int             serve_log[$];
  logic [DW-1:0]  out_log[$];
  int             tests_run = 0;
  int             fails     = 0;
  logic [PW-1:0]  e_pel;
  logic [SZW-1:0] e_size;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write is popped against its flux's expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if ((out_pel_write != '0) || (out_size_write != '0)) begin
        check("one_op_per_cycle",
              32'($countones(out_pel_write) + $countones(out_size_write)), 32'd1);
      end
      for (int f = 0; f < FLUX; f++) begin
        if (out_pel_write[f]) begin
          check("pel_tag", 32'(out_pel_din[PW-1 -: TW]), 32'(f));
          check("pel_full_respected", 32'(out_pel_full[f]), 32'd0);
          if (exp_q[f].size() == 0) begin
            check("pel_unexpected", 32'd1, 32'd0);
          end else begin
            e_pel = exp_q[f].pop_front();
            check("pel_value", 32'(out_pel_din), 32'(e_pel));
          end
          pel_cnt[f]++;
          serve_log.push_back(f);
          out_log.push_back(out_pel_din[DW-1:0]);
        end
        if (out_size_write[f]) begin
          check("size_tag", 32'(out_size_din[SZW-1 -: TW]), 32'(f));
          if (exp_size_q[f].size() == 0) begin
            check("size_unexpected", 32'd1, 32'd0);
          end else begin
            e_size = exp_size_q[f].pop_front();
            check("size_value", 32'(out_size_din), 32'(e_size));
          end
          size_cnt[f]++;
        end
      end
    end
  end

  task automatic refresh();
    for (int f = 0; f < FLUX; f++) begin
      in_pel_empty[f]   = (in_q[f].size() == 0);
      in_pel_dout[f]    = in_pel_empty[f] ? '0 : in_q[f][0];
      ext_size_empty[f] = (sz_q[f].size() == 0);
      ext_size_dout[f]  = ext_size_empty[f] ? '0 : sz_q[f][0];
    end
  endtask

  // One clock: capture strobes mid-cycle, pop the FIFO models after the edge.
  task automatic tick();
    logic [FLUX-1:0] prd;
    logic [FLUX-1:0] srd;
    @(negedge clk);
    prd = in_pel_read;
    srd = ext_size_read;
    @(posedge clk);
    #1;
    for (int f = 0; f < FLUX; f++) begin
      if (prd[f] && in_q[f].size() > 0) in_q[f].delete(0);
      if (srd[f] && sz_q[f].size() > 0) sz_q[f].delete(0);
    end
    refresh();
  endtask

  task automatic load_block(input int f, input int s, input int base, input int rstep);
    logic [PW-1:0] first_p;
    logic [PW-1:0] last_p;
    sz_q[f].push_back({TW'(f), SW'(s)});
    exp_size_q[f].push_back({TW'(f), SW'(s)});
    for (int r = 0; r < s; r++) begin
      for (int c = 0; c < s; c++) in_q[f].push_back({TW'(f), DW'(base + rstep * r + c)});
      first_p = {TW'(f), DW'(base + rstep * r)};
      last_p  = {TW'(f), DW'(base + rstep * r + s - 1)};
      for (int k = 0; k < PL; k++) exp_q[f].push_back(first_p);
      for (int c = 0; c < s; c++) exp_q[f].push_back({TW'(f), DW'(base + rstep * r + c)});
      for (int k = 0; k < PR; k++) exp_q[f].push_back(last_p);
    end
    refresh();
  endtask

  function automatic bit idle_all();
    bit ok = 1'b1;
    for (int f = 0; f < FLUX; f++) begin
      if (in_q[f].size() != 0 || sz_q[f].size() != 0) ok = 1'b0;
      if (exp_q[f].size() != 0 || exp_size_q[f].size() != 0) ok = 1'b0;
      if (dbg_state[f] != IDLE) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while (!idle_all() && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(idle_all()), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, s0, s1, n, zeros;
    out_pel_full  = '0;
    out_size_full = '0;
    refresh();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_cnt_h", 32'(dbg_cnt_h), 32'd0);
    check("rst_strobes", 32'({in_pel_read, ext_size_read, out_pel_write, out_size_write}), 32'd0);
    rst = 1'b1;
    tick();

    // Single block S=2, pels 10,11 / 20,21
    p0 = pel_cnt[0]; s0 = size_cnt[0];
    out_log.delete();
    load_block(0, 2, 10, 10);
    run_idle("t1", 200);
    check("t1_pel_count", 32'(pel_cnt[0] - p0), 32'd34);
    check("t1_size_count", 32'(size_cnt[0] - s0), 32'd1);
    check("t1_state", 32'(dbg_state[0]), 32'(IDLE));
    if (out_log.size() == 34) begin
      check("t1_left_pad", 32'(out_log[6]), 32'd10);
      check("t1_body_end", 32'(out_log[8]), 32'd11);
      check("t1_right_pad", 32'(out_log[16]), 32'd11);
      check("t1_row2_start", 32'(out_log[17]), 32'd20);
      check("t1_last", 32'(out_log[33]), 32'd21);
    end else begin
      check("t1_log_size", 32'(out_log.size()), 32'd34);
    end

    // S=0 token
    p0 = pel_cnt[0]; s0 = size_cnt[0];
    load_block(0, 0, 0, 0);
    run_idle("t2", 50);
    check("t2_pel_count", 32'(pel_cnt[0] - p0), 32'd0);
    check("t2_size_count", 32'(size_cnt[0] - s0), 32'd1);
    check("t2_state", 32'(dbg_state[0]), 32'(IDLE));

    // Two fluxes, S=1 each: flux 0 must finish before flux 1 writes any pel
    p0 = pel_cnt[0]; p1 = pel_cnt[1];
    serve_log.delete();
    load_block(0, 1, 100, 0);
    load_block(1, 1, 200, 0);
    run_idle("t3", 200);
    check("t3_flux0_count", 32'(pel_cnt[0] - p0), 32'd16);
    check("t3_flux1_count", 32'(pel_cnt[1] - p1), 32'd16);
    zeros = 0;
    for (int i = 0; i < 16 && i < serve_log.size(); i++) if (serve_log[i] == 0) zeros++;
    check("t3_arb_order", 32'(zeros), 32'd16);

    // Stall flux 0 mid-LEFT for 5 cycles while flux 1 proceeds
    load_block(0, 1, 300, 0);
    load_block(1, 1, 400, 0);
    n = 0;
    while (!(dbg_state[0] == LEFT && dbg_cnt_h[0] == 8'd3) && n < 50) begin
      tick();
      n++;
    end
    check("t4_reach_left3", 32'(n < 50), 32'd1);
    out_pel_full[0] = 1'b1;
    p0 = pel_cnt[0]; p1 = pel_cnt[1]; s1 = size_cnt[1];
    repeat (5) tick();
    check("t4_flux0_frozen", 32'(pel_cnt[0] - p0), 32'd0);
    check("t4_flux1_pels", 32'(pel_cnt[1] - p1), 32'd4);
    check("t4_flux1_size", 32'(size_cnt[1] - s1), 32'd1);
    check("t4_cnt_h_held", 32'(dbg_cnt_h[0]), 32'd3);
    check("t4_state_held", 32'(dbg_state[0]), 32'(LEFT));
    out_pel_full[0] = 1'b0;
    p0 = pel_cnt[0];
    run_idle("t4", 200);
    check("t4_flux0_rest", 32'(pel_cnt[0] - p0), 32'd13);

    // Reset mid-BODY, then a clean S=1 block
    load_block(0, 2, 500, 10);
    n = 0;
    while (dbg_state[0] != BODY && n < 50) begin
      tick();
      n++;
    end
    check("t5_reach_body", 32'(n < 50), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_strobes",
          32'({in_pel_read, ext_size_read, out_pel_write, out_size_write}), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'd0);
    check("t5_rst_cnt_h", 32'(dbg_cnt_h), 32'd0);
    for (int f = 0; f < FLUX; f++) begin
      in_q[f].delete();
      sz_q[f].delete();
      exp_q[f].delete();
      exp_size_q[f].delete();
    end
    refresh();
    @(posedge clk);
    #1;
    rst = 1'b1;
    p0 = pel_cnt[0];
    load_block(0, 1, 600, 0);
    run_idle("t5", 100);
    check("t5_pel_count", 32'(pel_cnt[0] - p0), 32'd16);

    // Back-to-back blocks S=3 then S=1
    p0 = pel_cnt[0]; s0 = size_cnt[0];
    load_block(0, 3, 700, 16);
    load_block(0, 1, 800, 0);
    run_idle("t6", 300);
    check("t6_pel_count", 32'(pel_cnt[0] - p0), 32'd70);
    check("t6_size_count", 32'(size_cnt[0] - s0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
